mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Arbitrates one shared RAM port between the instruction-fetch requester (driven by imemREN) and the data requester (driven by dREN/dWEN).
- Sits between the datapath request logic and RAM.
- Holds each requester in wait until its access completes.
- Uses a registered grant FSM with data priority and an alternation rule so fetch cannot starve.

Parameters:
- TIMEOUT_CYCLES, 64: max cycles a grant may stay without RAM ACCESS before forced completion with error.
- ERR_WORD, 32'hBAD1BAD1: load value returned on RAM ERROR or timeout.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- iREN  input  1  instruction read request.
- iaddr  input  32  instruction address.
- iwait  output  1  instruction stall; 0 only in the completion cycle.
- iload  output  32  instruction read data.
- dREN  input  1  data read request.
- dWEN  input  1  data write request.
- daddr  input  32  data address.
- dstore  input  32  data write value.
- dwait  output  1  data stall; 0 only in the completion cycle.
- dload  output  32  data read data.
- ramREN  output  1  RAM read enable.
- ramWEN  output  1  RAM write enable.
- ramaddr  output  32  RAM address.
- ramstore  output  32  RAM write data.
- ramload  input  32  RAM read data.
- ramstate  input  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- bus_err  output  1  sticky error flag.

Behaviour:
- FSM states: IDLE, DGRANT, IGRANT. Reset state is IDLE.
- Reset values:
  - FSM=IDLE, last_d=0, tmo_cnt=0, bus_err=0.
  - ramREN=ramWEN=0, ramaddr=ramstore=0.
  - iwait=iREN, dwait=(dREN|dWEN). These are combinational: waits equal the requests while no access completes.
- Reset is asynchronous. Asserting nRST low mid-grant aborts the access immediately: RAM enables drop to 0 in the same cycle with no completion pulse.
- IDLE transitions:
  - dreq=(dREN|dWEN).
  - If dreq and not (last_d and iREN): go to DGRANT.
  - Else if iREN: go to IGRANT.
  - Else: stay in IDLE.
  - Nothing is driven to RAM while in IDLE.
  - Minimum latency: request at cycle 0, grant at cycle 1, earliest completion at cycle 1.
- DGRANT outputs (combinational from current inputs):
  - ramaddr=daddr, ramstore=dstore.
  - ramWEN=dWEN, ramREN=dREN & ~dWEN. Write wins if both are asserted.
- IGRANT outputs: ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0.
- Completion when ramstate==ACCESS in a grant state:
  - Granted wait=0 for exactly that cycle.
  - dload or iload = ramload, passed through.
  - Next state is IDLE. last_d is set to 1 if the grant was DGRANT, else 0.
- ERROR handling, when ramstate==ERROR in a grant state:
  - Complete as for ACCESS, but load data = ERR_WORD.
  - Set bus_err=1, which holds until reset.
- BUSY or FREE in a grant state:
  - Hold the grant and increment tmo_cnt.
  - If tmo_cnt reaches TIMEOUT_CYCLES-1, force completion as in the ERROR case.
  - tmo_cnt clears on any exit from a grant state.
- Request withdrawn while granted (the granted requester's REN/WEN low):
  - RAM enables drop combinationally.
  - FSM returns to IDLE next cycle. No completion pulse, last_d unchanged.
- Non-granted requester: its wait follows its request; its load output is 0.
- Simultaneous iREN and dreq with last_d=0: data wins. Fetch is served next because last_d becomes 1.
- Back-to-back: every access passes through one IDLE cycle. A requester holding REN continuously is re-granted after that cycle.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Defined: adds output ports iacc_count[31:0], dacc_count[31:0] and stall_count[31:0].
  - iacc_count and dacc_count increment on each completed I or D access, including error completions.
  - stall_count increments every cycle that iwait or dwait is 1.
  - All three reset to 0 and wrap modulo 2^32.
- Undefined: those ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: nRST=0 -> FSM IDLE, ramREN=ramWEN=0, bus_err=0. iREN=1 shows iwait=1 with no RAM activity.
- Single fetch: iREN=1, iaddr=0x40, ramstate BUSY 2 cycles then ACCESS, ramload=0x8C010004 -> ramREN=1, ramaddr=0x40 from cycle 1; iwait=0 and iload=0x8C010004 on cycle 3; IDLE on cycle 4.
- Contention: iREN=1 and dWEN=1 (daddr=0x100, dstore=0xDEAD) from IDLE with last_d=0 -> DGRANT first, ramWEN=1, ramstore=0xDEAD. After ACCESS, one IDLE cycle, then IGRANT even though dREN is still asserted.
- Error: during DGRANT with dREN=1, ramstate=ERROR -> dwait=0, dload=0xBAD1BAD1, bus_err=1 until the next reset.
- Timeout: TIMEOUT_CYCLES=4, ramstate held BUSY -> forced completion on the 4th grant cycle with ERR_WORD, bus_err=1.
- Mid-access abort: nRST pulsed low during IGRANT BUSY -> RAM enables drop asynchronously and no iwait=0 pulse. With MEM_ARB_STATS_EN defined, all counters read 0 after reset.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Request/RAM bundle between the two requesters, the arbiter and the RAM port.
// slave: arbiter view; master: requester/RAM side that drives requests and RAM status.
interface mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        bus_err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, bus_err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, bus_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shared-RAM arbiter: data priority, alternation after a data access, grant timeout -> ERR_WORD.
// Latency: grant one cycle after request, completion earliest in the grant cycle; one IDLE cycle between accesses.
// Backpressure: requesters stall on iwait/dwait until completion; MEM_ARB_STATS_EN adds access/stall counters.
module mem_arbiter #(
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] ERR_WORD       = 32'hBAD1BAD1
) (
    input  logic          CLK,
    input  logic          nRST,
    mem_arbiter_if.slave  bus
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]   iacc_count,
    output logic [31:0]   dacc_count,
    output logic [31:0]   stall_count
`endif
);

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          last_d_q, last_d_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          bus_err_q, bus_err_d;

    logic          dreq;
    logic          i_done;
    logic          d_done;
    logic          done_err;
    logic          ram_ren;
    logic          ram_wen;
    logic [31:0]   ram_addr;
    logic [31:0]   ram_store;
    logic [31:0]   done_load;
    logic          iwait_c;
    logic          dwait_c;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            last_d_q  <= 1'b0;
            tmo_cnt_q <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_d_q  <= last_d_d;
            tmo_cnt_q <= tmo_cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d_d  = last_d_q;
        tmo_cnt_d = '0;
        bus_err_d = bus_err_q;
        ram_ren   = 1'b0;
        ram_wen   = 1'b0;
        ram_addr  = '0;
        ram_store = '0;
        i_done    = 1'b0;
        d_done    = 1'b0;
        done_err  = 1'b0;
        dreq      = bus.dREN | bus.dWEN;

        case (state_q)
            IDLE: begin
                // last_d hands the next contested slot to fetch so it cannot starve
                if (dreq && !(last_d_q && bus.iREN)) begin
                    state_d = DGRANT;
                end else if (bus.iREN) begin
                    state_d = IGRANT;
                end
            end

            DGRANT: begin
                ram_addr  = bus.daddr;
                ram_store = bus.dstore;
                ram_wen   = bus.dWEN;
                ram_ren   = bus.dREN & ~bus.dWEN;
                if (!dreq) begin
                    state_d = IDLE;
                end else if (bus.ramstate == RAM_ACCESS || bus.ramstate == RAM_ERROR ||
                             tmo_cnt_q == TMO_LAST) begin
                    d_done   = 1'b1;
                    done_err = (bus.ramstate != RAM_ACCESS);
                    state_d  = IDLE;
                    last_d_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end

            IGRANT: begin
                ram_addr = bus.iaddr;
                ram_ren  = bus.iREN;
                if (!bus.iREN) begin
                    state_d = IDLE;
                end else if (bus.ramstate == RAM_ACCESS || bus.ramstate == RAM_ERROR ||
                             tmo_cnt_q == TMO_LAST) begin
                    i_done   = 1'b1;
                    done_err = (bus.ramstate != RAM_ACCESS);
                    state_d  = IDLE;
                    last_d_d = 1'b0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (done_err) begin
            bus_err_d = 1'b1;
        end
    end

    assign done_load = done_err ? ERR_WORD : bus.ramload;
    assign iwait_c   = bus.iREN & ~i_done;
    assign dwait_c   = dreq & ~d_done;

    assign bus.iwait    = iwait_c;
    assign bus.dwait    = dwait_c;
    assign bus.iload    = i_done ? done_load : 32'd0;
    assign bus.dload    = d_done ? done_load : 32'd0;
    assign bus.ramREN   = ram_ren;
    assign bus.ramWEN   = ram_wen;
    assign bus.ramaddr  = ram_addr;
    assign bus.ramstore = ram_store;
    assign bus.bus_err  = bus_err_q;

`ifdef MEM_ARB_STATS_EN
    logic [31:0] iacc_cnt_q, iacc_cnt_d;
    logic [31:0] dacc_cnt_q, dacc_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            iacc_cnt_q  <= '0;
            dacc_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            iacc_cnt_q  <= iacc_cnt_d;
            dacc_cnt_q  <= dacc_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        iacc_cnt_d  = iacc_cnt_q + {31'd0, i_done};
        dacc_cnt_d  = dacc_cnt_q + {31'd0, d_done};
        stall_cnt_d = stall_cnt_q + {31'd0, (iwait_c | dwait_c)};
    end

    assign iacc_count  = iacc_cnt_q;
    assign dacc_count  = dacc_cnt_q;
    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; a negedge monitor pops expected completions from a queue.
module tb_mem_arbiter;

    typedef struct packed {
        logic        is_d;
        logic [31:0] data;
    } exp_t;

    logic CLK;
    logic nRST;
    int   n_vec;
    int   n_err;
    exp_t exp_q[$];

    mem_arbiter_if bus();

`ifdef MEM_ARB_STATS_EN
    logic [31:0] iacc_count;
    logic [31:0] dacc_count;
    logic [31:0] stall_count;
`endif

    mem_arbiter #(
        .TIMEOUT_CYCLES(4),
        .ERR_WORD(32'hBAD1BAD1)
    ) dut (
        .CLK(CLK),
        .nRST(nRST),
        .bus(bus)
`ifdef MEM_ARB_STATS_EN
        ,
        .iacc_count(iacc_count),
        .dacc_count(dacc_count),
        .stall_count(stall_count)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_done(input logic is_d, input logic [31:0] data);
        exp_t e;
        e.is_d = is_d;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Monitor: any completion pulse must match the oldest queued expectation
    always @(negedge CLK) begin
        if (nRST) begin
            if (bus.iREN && !bus.iwait) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_i_completion", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("i_completion_kind", {31'd0, e.is_d}, 32'd0);
                    chk("iload", bus.iload, e.data);
                end
            end
            if ((bus.dREN || bus.dWEN) && !bus.dwait) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_d_completion", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("d_completion_kind", {31'd0, e.is_d}, 32'd1);
                    chk("dload", bus.dload, e.data);
                end
            end
        end
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        nRST         = 1'b0;
        bus.iREN     = 1'b0;
        bus.iaddr    = '0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.daddr    = '0;
        bus.dstore   = '0;
        bus.ramload  = '0;
        bus.ramstate = 2'd0;

        // Reset state
        #2;
        chk("rst_ramREN", {31'd0, bus.ramREN}, 32'd0);
        chk("rst_ramWEN", {31'd0, bus.ramWEN}, 32'd0);
        chk("rst_bus_err", {31'd0, bus.bus_err}, 32'd0);
        chk("rst_ramaddr", bus.ramaddr, 32'd0);
        bus.iREN = 1'b1;
        #1;
        chk("rst_iwait_follows_iREN", {31'd0, bus.iwait}, 32'd1);
        chk("rst_no_ram_read", {31'd0, bus.ramREN}, 32'd0);
        bus.iREN = 1'b0;
        tick();
        nRST = 1'b1;
        tick();

        // Single fetch: BUSY, BUSY, ACCESS
        bus.iREN = 1'b1;
        bus.iaddr = 32'h40;
        bus.ramstate = 2'd1;
        #1;
        chk("fetch_idle_iwait", {31'd0, bus.iwait}, 32'd1);
        chk("fetch_idle_ramREN", {31'd0, bus.ramREN}, 32'd0);
        tick();
        chk("fetch_c1_ramREN", {31'd0, bus.ramREN}, 32'd1);
        chk("fetch_c1_ramaddr", bus.ramaddr, 32'h40);
        chk("fetch_c1_iwait", {31'd0, bus.iwait}, 32'd1);
        tick();
        chk("fetch_c2_iwait", {31'd0, bus.iwait}, 32'd1);
        tick();
        bus.ramstate = 2'd2;
        bus.ramload = 32'h8C010004;
        expect_done(1'b0, 32'h8C010004);
        #1;
        chk("fetch_c3_iwait", {31'd0, bus.iwait}, 32'd0);
        tick();
        chk("fetch_c4_idle_ramREN", {31'd0, bus.ramREN}, 32'd0);
        bus.iREN = 1'b0;
        bus.ramstate = 2'd0;

        // Contention with last_d=0: data first, then fetch after one IDLE cycle
        bus.iREN = 1'b1;
        bus.iaddr = 32'h80;
        bus.dWEN = 1'b1;
        bus.daddr = 32'h100;
        bus.dstore = 32'hDEAD;
        bus.ramstate = 2'd1;
        tick();
        chk("cont_dgrant_ramWEN", {31'd0, bus.ramWEN}, 32'd1);
        chk("cont_dgrant_ramREN", {31'd0, bus.ramREN}, 32'd0);
        chk("cont_dgrant_ramaddr", bus.ramaddr, 32'h100);
        chk("cont_dgrant_ramstore", bus.ramstore, 32'hDEAD);
        chk("cont_dgrant_iwait", {31'd0, bus.iwait}, 32'd1);
        chk("cont_dgrant_iload", bus.iload, 32'd0);
        bus.ramstate = 2'd2;
        bus.ramload = 32'h12345678;
        expect_done(1'b1, 32'h12345678);
        #1;
        chk("cont_dwait_done", {31'd0, bus.dwait}, 32'd0);
        tick();
        bus.dWEN = 1'b0;
        bus.dREN = 1'b1;
        bus.ramstate = 2'd1;
        #1;
        chk("cont_idle_ramREN", {31'd0, bus.ramREN}, 32'd0);
        chk("cont_idle_ramWEN", {31'd0, bus.ramWEN}, 32'd0);
        tick();
        chk("cont_igrant_ramaddr", bus.ramaddr, 32'h80);
        chk("cont_igrant_ramREN", {31'd0, bus.ramREN}, 32'd1);
        chk("cont_igrant_ramstore", bus.ramstore, 32'd0);
        chk("cont_igrant_dwait", {31'd0, bus.dwait}, 32'd1);
        chk("cont_igrant_dload", bus.dload, 32'd0);
        bus.ramstate = 2'd2;
        bus.ramload = 32'h11110000;
        expect_done(1'b0, 32'h11110000);
        tick();
        bus.iREN = 1'b0;
        bus.ramstate = 2'd1;
        bus.daddr = 32'h200;

        // Error completion during a data read
        tick();
        chk("err_dgrant_ramREN", {31'd0, bus.ramREN}, 32'd1);
        chk("err_dgrant_ramaddr", bus.ramaddr, 32'h200);
        bus.ramstate = 2'd3;
        bus.ramload = 32'h55555555;
        expect_done(1'b1, 32'hBAD1BAD1);
        #1;
        chk("err_bus_err_before_edge", {31'd0, bus.bus_err}, 32'd0);
        chk("err_dwait", {31'd0, bus.dwait}, 32'd0);
        tick();
        bus.dREN = 1'b0;
        bus.ramstate = 2'd0;
        chk("err_bus_err_set", {31'd0, bus.bus_err}, 32'd1);
        tick();
        tick();
        chk("err_bus_err_sticky", {31'd0, bus.bus_err}, 32'd1);

        // Reset clears the sticky flag; then a timeout on a BUSY RAM
        nRST = 1'b0;
        #1;
        chk("rst2_bus_err", {31'd0, bus.bus_err}, 32'd0);
        tick();
        nRST = 1'b1;
        tick();
        bus.dREN = 1'b1;
        bus.daddr = 32'h300;
        bus.ramstate = 2'd1;
        tick();
        chk("tmo_c1_dwait", {31'd0, bus.dwait}, 32'd1);
        tick();
        tick();
        chk("tmo_c3_dwait", {31'd0, bus.dwait}, 32'd1);
        tick();
        expect_done(1'b1, 32'hBAD1BAD1);
        #1;
        chk("tmo_c4_dwait", {31'd0, bus.dwait}, 32'd0);
        tick();
        bus.dREN = 1'b0;
        chk("tmo_bus_err", {31'd0, bus.bus_err}, 32'd1);
        tick();

        // Withdrawn fetch: enable drops at once, no completion
        bus.iREN = 1'b1;
        bus.iaddr = 32'h44;
        bus.ramstate = 2'd1;
        tick();
        chk("wd_igrant_ramREN", {31'd0, bus.ramREN}, 32'd1);
        bus.iREN = 1'b0;
        #1;
        chk("wd_ramREN_dropped", {31'd0, bus.ramREN}, 32'd0);
        tick();
        tick();

        // Asynchronous abort mid-grant
        bus.iREN = 1'b1;
        bus.iaddr = 32'h48;
        bus.ramstate = 2'd1;
        tick();
        chk("abort_igrant_ramREN", {31'd0, bus.ramREN}, 32'd1);
        #1;
        nRST = 1'b0;
        #1;
        chk("abort_ramREN", {31'd0, bus.ramREN}, 32'd0);
        chk("abort_ramaddr", bus.ramaddr, 32'd0);
        chk("abort_iwait", {31'd0, bus.iwait}, 32'd1);
`ifdef MEM_ARB_STATS_EN
        chk("abort_iacc_count", iacc_count, 32'd0);
        chk("abort_dacc_count", dacc_count, 32'd0);
        chk("abort_stall_count", stall_count, 32'd0);
`endif
        bus.iREN = 1'b0;
        tick();
        tick();
        nRST = 1'b1;
        tick();
        tick();
        chk("pending_expectations", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
